// File: rtl/vga_sync_monitor.sv
// VGA timing monitor: recovers h/v position from the syncs, checks line and frame
// lengths, locks after consecutive good frames and sums visible pixels per frame.
module vga_sync_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACT       = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACT       = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  red,
    input  logic [2:0]  green,
    input  logic [1:0]  blue,
    output logic        locked,
    output logic        active,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic [7:0]  pixel,
    output logic        frame_start,
    output logic [23:0] frame_sum,
    output logic [15:0] frame_count,
    output logic        err_hlen,
    output logic        err_vlen,
    output logic        err_sticky
);
    localparam int H_LO = H_SYNC + H_BP;
    localparam int H_HI = H_LO + H_ACT;
    localparam int V_LO = V_SYNC + V_BP;
    localparam int V_HI = V_LO + V_ACT;

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t      state;
    logic        hs_q, vs_q, vpend, hseen, vseen;
    logic [9:0]  hcnt, vcnt;
    logic [7:0]  good;
    logic [23:0] acc;

    logic        line_start, vfall, fstart, eh, ev, err, lock_n, act_n;
    logic [9:0]  hcnt_n, vcnt_n;
    logic [7:0]  pix_n;

    always_comb begin
        pix_n      = {red, green, blue};
        line_start = hs_q & ~hsync;
        vfall      = vs_q & ~vsync;
        // a vsync edge coincident with a line start opens the frame on that very line
        fstart     = line_start & (vpend | vfall);

        hcnt_n = hcnt;
        if (line_start)
            hcnt_n = '0;
        else if (hcnt != 10'd1023)
            hcnt_n = hcnt + 10'd1;

        vcnt_n = vcnt;
        if (fstart)
            vcnt_n = '0;
        else if (line_start && vcnt != 10'd1023)
            vcnt_n = vcnt + 10'd1;

        // hseen/vseen mask the partial line/frame that follows reset
        eh  = line_start & hseen & ((11'(hcnt) + 11'd1) != 11'(H_TOTAL));
        ev  = fstart & vseen & ((11'(vcnt) + 11'd1) != 11'(V_TOTAL));
        err = eh | ev;

        lock_n = !err && (state == LOCKED ||
                 (state == TRACK && fstart && (good + 8'd1) == 8'(LOCK_FRAMES)));
        act_n  = lock_n && hcnt_n >= 10'(H_LO) && hcnt_n < 10'(H_HI)
                        && vcnt_n >= 10'(V_LO) && vcnt_n < 10'(V_HI);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            vpend       <= 1'b0;
            hseen       <= 1'b0;
            vseen       <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            good        <= '0;
            acc         <= '0;
            locked      <= 1'b0;
            active      <= 1'b0;
            pos_x       <= '0;
            pos_y       <= '0;
            pixel       <= '0;
            frame_start <= 1'b0;
            frame_sum   <= '0;
            frame_count <= '0;
            err_hlen    <= 1'b0;
            err_vlen    <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            err_hlen    <= 1'b0;
            err_vlen    <= 1'b0;
            if (pix_en) begin
                hs_q        <= hsync;
                vs_q        <= vsync;
                hcnt        <= hcnt_n;
                vcnt        <= vcnt_n;
                pixel       <= pix_n;
                frame_start <= fstart;
                err_hlen    <= eh;
                err_vlen    <= ev;
                locked      <= lock_n;
                active      <= act_n;
                if (line_start)
                    hseen <= 1'b1;
                if (fstart) begin
                    vseen <= 1'b1;
                    vpend <= 1'b0;
                end else if (vfall) begin
                    vpend <= 1'b1;
                end
                if (act_n) begin
                    pos_x <= hcnt_n - 10'(H_LO);
                    pos_y <= vcnt_n - 10'(V_LO);
                end
                if (fstart) begin
                    frame_sum <= acc;
                    acc       <= act_n ? 24'(pix_n) : 24'd0;
                end else if (act_n) begin
                    acc <= acc + 24'(pix_n);
                end

                case (state)
                    SEARCH: if (fstart && !err) begin
                        state <= TRACK;
                        good  <= '0;
                    end
                    TRACK: begin
                        if (err)
                            state <= SEARCH;
                        else if (fstart) begin
                            good <= good + 8'd1;
                            if ((good + 8'd1) == 8'(LOCK_FRAMES))
                                state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        // an error on a frame-start sample drops lock and the frame goes uncounted
                        if (err) begin
                            state      <= SEARCH;
                            err_sticky <= 1'b1;
                        end else if (fstart) begin
                            frame_count <= frame_count + 16'd1;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Randomised bench for vga_sync_monitor on a scaled-down raster, checked against a
// sample-level reference model derived from the timing rules.
module tb_vga_sync_monitor;
    localparam int HT = 20, HS = 3, HB = 2, HA = 12;
    localparam int VT = 12, VS = 2, VB = 2, VA = 6;
    localparam int LF = 2;

    logic        clk = 1'b0;
    logic        reset, pix_en, hsync, vsync;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic        locked, active, frame_start, err_hlen, err_vlen, err_sticky;
    logic [9:0]  pos_x, pos_y;
    logic [7:0]  pixel;
    logic [23:0] frame_sum;
    logic [15:0] frame_count;

    always #10 clk = ~clk;

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACT(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .locked(locked), .active(active), .pos_x(pos_x), .pos_y(pos_y),
        .pixel(pixel), .frame_start(frame_start), .frame_sum(frame_sum),
        .frame_count(frame_count), .err_hlen(err_hlen), .err_vlen(err_vlen),
        .err_sticky(err_sticky)
    );

    int checks = 0, errors = 0;
    int mode = 0;
    int n_eh = 0, n_ev = 0, n_fs = 0;

    // reference model: phase 0 searching, 1 tracking, 2 locked
    int m_hprev, m_vprev, m_h, m_v, m_pend, m_hseen, m_vseen;
    int m_phase, m_good, m_acc, m_fsum, m_fc, m_sticky;
    int m_px, m_py, m_pix, m_act, m_fs, m_eh, m_ev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
            if (errors >= 40) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    endtask

    task automatic m_reset();
        m_hprev = 0; m_vprev = 0; m_h = 0; m_v = 0; m_pend = 0; m_hseen = 0; m_vseen = 0;
        m_phase = 0; m_good = 0; m_acc = 0; m_fsum = 0; m_fc = 0; m_sticky = 0;
        m_px = 0; m_py = 0; m_pix = 0; m_act = 0; m_fs = 0; m_eh = 0; m_ev = 0;
    endtask

    task automatic m_step(input int hs, input int vs, input int pix);
        int ls, vf, err;
        ls = (m_hprev == 1 && hs == 0);
        vf = (m_vprev == 1 && vs == 0);
        m_fs = 0; m_eh = 0; m_ev = 0;
        if (ls) begin
            if (m_hseen && m_h + 1 != HT) m_eh = 1;
            m_hseen = 1;
            m_h = 0;
            if (m_pend || vf) begin
                m_fs = 1;
                if (m_vseen && m_v + 1 != VT) m_ev = 1;
                m_vseen = 1;
                m_v = 0;
                m_pend = 0;
            end else if (m_v < 1023) m_v++;
        end else begin
            if (m_h < 1023) m_h++;
            if (vf) m_pend = 1;
        end
        err = m_eh || m_ev;
        if (err) begin
            if (m_phase == 2) m_sticky = 1;
            m_phase = 0;
        end else if (m_fs) begin
            if (m_phase == 0) begin m_phase = 1; m_good = 0; end
            else if (m_phase == 1) begin m_good++; if (m_good == LF) m_phase = 2; end
            else m_fc = (m_fc + 1) % 65536;
        end
        m_act = (m_phase == 2) && m_h >= HS + HB && m_h < HS + HB + HA
                && m_v >= VS + VB && m_v < VS + VB + VA;
        if (m_fs) begin m_fsum = m_acc; m_acc = 0; end
        if (m_act) begin
            m_px = m_h - (HS + HB);
            m_py = m_v - (VS + VB);
            m_acc = (m_acc + pix) % (1 << 24);
        end
        m_pix = pix;
        m_hprev = hs;
        m_vprev = vs;
    endtask

    task automatic chk_all();
        chk("locked", locked, m_phase == 2);
        chk("active", active, m_act);
        chk("pos_x", pos_x, m_px);
        chk("pos_y", pos_y, m_py);
        chk("pixel", pixel, m_pix);
        chk("frame_start", frame_start, m_fs);
        chk("frame_sum", frame_sum, m_fsum);
        chk("frame_count", frame_count, m_fc);
        chk("err_hlen", err_hlen, m_eh);
        chk("err_vlen", err_vlen, m_ev);
        chk("err_sticky", err_sticky, m_sticky);
    endtask

    task automatic tick(input int en, input int hs, input int vs, input int pix);
        logic [7:0] p8;
        p8 = pix[7:0];
        @(negedge clk);
        pix_en = en[0]; hsync = hs[0]; vsync = vs[0];
        {red, green, blue} = p8;
        @(posedge clk);
        #1;
        if (en != 0) m_step(hs, vs, int'(p8));
        else begin m_fs = 0; m_eh = 0; m_ev = 0; end
        if (err_hlen) n_eh++;
        if (err_vlen) n_ev++;
        if (frame_start) n_fs++;
        chk_all();
    endtask

    // one pixel sample followed by mostly one idle clock carrying junk inputs
    task automatic sample(input int hs, input int vs);
        int pix, idle;
        pix = (mode == 1) ? 255 : int'($urandom_range(0, 255));
        tick(1, hs, vs, pix);
        idle = ($urandom % 8 == 0) ? int'($urandom % 3) : 1;
        for (int i = 0; i < idle; i++)
            tick(0, int'($urandom % 2), int'($urandom % 2), int'($urandom % 256));
    endtask

    task automatic line(input int len, input int vlow);
        for (int c = 0; c < len; c++)
            sample(c < HS ? 0 : 1, vlow ? 0 : 1);
    endtask

    task automatic frame(input int nlines, input int short_ln, input int first);
        for (int l = first; l < nlines; l++)
            line(l == short_ln ? HT - 1 : HT, l < VS);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        pix_en = 1'(($urandom % 2));
        @(posedge clk);
        #1;
        m_reset();
        chk_all();
        chk("rst_locked", locked, 0);
        chk("rst_active", active, 0);
        chk("rst_sum", frame_sum, 0);
        chk("rst_sticky", err_sticky, 0);
        reset = 1'b0;
        pix_en = 1'b0;
    endtask

    initial begin
        int k;
        reset = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
        red = '0; green = '0; blue = '0;
        m_reset();
        do_reset();

        // blanking pre-roll so the first frame opens with a real sync edge
        repeat (5) sample(1, 1);
        repeat (4) frame(VT, -1, 0);
        chk("lock4_locked", locked, 1);
        chk("lock4_count", frame_count, 1);
        chk("lock4_errs", n_eh + n_ev, 0);
        chk("lock4_starts", n_fs, 4);

        mode = 1;
        frame(VT, -1, 0);
        mode = 0;
        frame(VT, -1, 0);
        chk("ff_sum", frame_sum, (HA * VA * 255) % (1 << 24));

        n_eh = 0;
        frame(VT, 5, 0);
        chk("hlen_pulses", n_eh, 1);
        chk("hlen_unlock", locked, 0);
        chk("hlen_sticky", err_sticky, 1);

        k = 0;
        while (!locked && k < 6) begin frame(VT, -1, 0); k++; end
        chk("relock_h", locked, 1);

        n_ev = 0;
        frame(VT - 1, -1, 0);
        frame(VT, -1, 0);
        chk("vlen_pulses", n_ev, 1);
        chk("vlen_unlock", locked, 0);
        k = 0;
        while (!locked && k < 6) begin frame(VT, -1, 0); k++; end
        chk("relock_v", locked, 1);

        frame(7, -1, 0);
        do_reset();
        n_eh = 0; n_ev = 0;
        frame(VT, -1, 7);
        repeat (3) frame(VT, -1, 0);
        chk("rst_noerr", n_eh + n_ev, 0);
        chk("rst_relock", locked, 1);
        chk("rst_sticky_clr", err_sticky, 0);

        repeat (6) begin
            int nl, sl;
            nl = ($urandom % 4 == 0) ? VT + int'($urandom % 3) - 1 : VT;
            sl = ($urandom % 3 == 0) ? int'($urandom % VT) : -1;
            frame(nl, sl, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
